reg8: RTL and testbench
=======================

// Module: reg8
//
// PURPOSE
// - Parallel-load holding register, WIDTH bits wide (default 8); captures di on a clock edge when PL is high.
// - Generic datapath storage element: operand latch, config register, pipeline hold stage.
// - Adds a synchronous active-low reset and a "loaded since reset" status flag.
//
// PARAMETERS
// - WIDTH      8      data width in bits, legal range 1..64
// - RST_VAL    '0     value placed on dout by reset, WIDTH bits
//
// PORTS
// - clk    in   1      clock, all state updates on posedge
// - rst_n  in   1      reset, synchronous, active-low
// - PL     in   1      parallel-load enable, active-high
// - di     in   WIDTH  parallel data in
// - dout   out  WIDTH  registered data out (the port is not named do because do is an SV keyword)
// - vld    out  1      high once any load has occurred since the last reset
// - SH     in   1      shift enable; exists only when REG8_SHIFT_EN is defined
// - si     in   1      serial in (enters at the LSB); exists only when REG8_SHIFT_EN is defined
// - so     out  1      serial out, equal to dout[WIDTH-1]; exists only when REG8_SHIFT_EN is defined
//
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-low, sampled on posedge clk.
// - Priority at each posedge clk, highest first: reset > PL > SH > hold.
// - Reset (rst_n=0):
//   - dout <= RST_VAL and vld <= 0.
//   - PL, SH and di are ignored in that cycle.
//   - A reset during a load cancels the load.
// - Load (PL=1):
//   - dout <= di, visible one cycle after the edge.
//   - vld <= 1.
//   - When PL stays high, a new di is captured every edge.
// - Hold (PL=0, SH=0 or no shift feature): dout and vld are unchanged; di changes have no effect.
// - Outputs are purely registered, with no combinational path from di/PL to dout.
// - After reset deassertion, dout holds RST_VAL until the first load.
// - Width rules:
//   - di and dout are both exactly WIDTH bits; there is no sign or zero handling inside the block.
//   - Narrower sources are zero-extended by the instantiating module.
// - Because vld is a register, it never toggles glitchily.
//
// CONFIGURATION
// - REG8_SHIFT_EN defined:
//   - Adds the SH, si and so ports.
//   - When PL=0 and SH=1: dout <= {dout[WIDTH-2:0], si}. For WIDTH=1: dout <= si.
//   - so is combinational from dout[WIDTH-1], i.e. a registered bit.
//   - A shift does not change vld.
// - REG8_SHIFT_EN undefined: the SH, si and so ports are absent and the block only loads or holds.
//
// STRUCTURE
// - Package reg8_pkg:
//   - REG8_DEF_WIDTH = 8.
//   - typedef enum {R8_HOLD, R8_LOAD, R8_SHIFT} reg8_op_e, the decoded per-cycle operation.
// - A single always_ff implements the priority mux. No sub-module is needed.
// - A per-bit cell named reg8_bit is permitted when a generate-based bit-slice implementation is preferred.
//
// TESTING
// - 10 ns clock. After each edge, compare against a reference model.
// - Reset: rst_n=0 for 2 edges with PL=1, di=8'hA5 -> dout=8'h00, vld=0.
// - Hold:
//   - Release reset with PL=0, di=8'h07, for 2 edges -> dout=8'h00, vld=0.
// - Load:
//   - PL=1 for 2 edges with di=8'h07 -> dout=8'h07 after the first edge, vld=1.
//   - Then set PL=0 and change di to 8'hFF -> dout stays 8'h07.
// - Back-to-back loads: PL=1 with di=8'h11, then 8'h22, then 8'h33 on consecutive edges -> dout follows with 1-cycle latency.
// - Reset mid-operation:
//   - PL=1, di=8'h5A, and rst_n=0 on the same edge -> dout=8'h00, vld=0.
//   - Next edge with rst_n=1 -> dout=8'h5A.
// - Shift (REG8_SHIFT_EN only):
//   - Load 8'h81, then SH=1, si=0 for 1 edge -> dout=8'h02, so=0.
//   - PL=1 and SH=1 together with di=8'h3C -> load wins, dout=8'h3C.

Source files
------------

// File: rtl/reg8_pkg.sv
// Shared types for the reg8 holding register: default width and the decoded per-cycle operation.
package reg8_pkg;

  localparam int REG8_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    R8_HOLD  = 2'd0,
    R8_LOAD  = 2'd1,
    R8_SHIFT = 2'd2
  } reg8_op_e;

  // Load outranks shift; reset is handled separately in the register itself.
  function automatic reg8_op_e reg8_decode(input logic pl, input logic sh);
    reg8_op_e op;
    if (pl) begin
      op = R8_LOAD;
    end else if (sh) begin
      op = R8_SHIFT;
    end else begin
      op = R8_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/reg8.sv
// Parallel-load holding register with a "loaded since reset" flag and synchronous active-low reset.
// Optional serial shift path (SH/si/so ports) is enabled by defining REG8_SHIFT_EN.
module reg8
  import reg8_pkg::*;
#(
  parameter int                WIDTH   = REG8_DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PL,
  input  logic [WIDTH-1:0] di,
`ifdef REG8_SHIFT_EN
  input  logic             SH,
  input  logic             si,
  output logic             so,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             vld
);

  logic [WIDTH-1:0] r_dout;
  logic             r_vld;
  logic             w_sh;
  logic             w_si;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;
  logic             w_vld_next;
  reg8_op_e         w_op;

`ifdef REG8_SHIFT_EN
  assign w_sh = SH;
  assign w_si = si;
  assign so   = r_dout[WIDTH-1];
`else
  assign w_sh = 1'b0;
  assign w_si = 1'b0;
`endif

  // A one-bit register has no upper bits to keep, so the shift degenerates to capturing si.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign w_shifted = w_si;
    end else begin : g_shift_wn
      assign w_shifted = {r_dout[WIDTH-2:0], w_si};
    end
  endgenerate

  // Next-state mux for data and valid flag.
  always_comb begin
    w_op       = reg8_decode(PL, w_sh);
    w_next     = r_dout;
    w_vld_next = r_vld;
    case (w_op)
      R8_LOAD: begin
        w_next     = di;
        w_vld_next = 1'b1;
      end
      R8_SHIFT: begin
        w_next     = w_shifted;
        w_vld_next = r_vld;
      end
      default: begin
        w_next     = r_dout;
        w_vld_next = r_vld;
      end
    endcase
  end

  // State register; reset wins over any load or shift in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout <= RST_VAL;
      r_vld  <= 1'b0;
    end else begin
      r_dout <= w_next;
      r_vld  <= w_vld_next;
    end
  end

  assign dout = r_dout;
  assign vld  = r_vld;

endmodule

// File: tb/tb_reg8.sv
// Directed self-checking bench for reg8; shift vectors run when REG8_SHIFT_EN is defined.
module tb_reg8;

  logic       clk;
  logic       rst_n;
  logic       PL;
  logic [7:0] di;
  logic [7:0] dout;
  logic       vld;
`ifdef REG8_SHIFT_EN
  logic       SH;
  logic       si;
  logic       so;
`endif

  int n_checks;
  int n_errors;

  reg8 #(.WIDTH(8), .RST_VAL(8'h00)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .PL    (PL),
    .di    (di),
`ifdef REG8_SHIFT_EN
    .SH    (SH),
    .si    (si),
    .so    (so),
`endif
    .dout  (dout),
    .vld   (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] d, input logic v);
    chk({tag, "_dout"}, {56'd0, dout}, {56'd0, d});
    chk({tag, "_vld"}, {63'd0, vld}, {63'd0, v});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    PL    = 1'b1;
    di    = 8'hA5;
`ifdef REG8_SHIFT_EN
    SH = 1'b0;
    si = 1'b0;
`endif

    // Reset with a load pending: load must be ignored.
    step(); expect_state("rst1", 8'h00, 1'b0);
    step(); expect_state("rst2", 8'h00, 1'b0);

    rst_n = 1'b1; PL = 1'b0; di = 8'h07;
    step(); expect_state("hold_after_rst1", 8'h00, 1'b0);
    step(); expect_state("hold_after_rst2", 8'h00, 1'b0);

    PL = 1'b1; di = 8'h07;
    step(); expect_state("load07_a", 8'h07, 1'b1);
    step(); expect_state("load07_b", 8'h07, 1'b1);

    PL = 1'b0; di = 8'hFF;
    step(); expect_state("hold07_a", 8'h07, 1'b1);
    step(); expect_state("hold07_b", 8'h07, 1'b1);

    PL = 1'b1;
    di = 8'h11; step(); expect_state("b2b_11", 8'h11, 1'b1);
    di = 8'h22; step(); expect_state("b2b_22", 8'h22, 1'b1);
    di = 8'h33; step(); expect_state("b2b_33", 8'h33, 1'b1);

    di = 8'h5A; rst_n = 1'b0;
    step(); expect_state("rst_mid", 8'h00, 1'b0);
    rst_n = 1'b1;
    step(); expect_state("load_after_rst", 8'h5A, 1'b1);
    PL = 1'b0; di = 8'hC3;
    step(); expect_state("hold5A", 8'h5A, 1'b1);

`ifdef REG8_SHIFT_EN
    PL = 1'b1; SH = 1'b0; di = 8'h81;
    step(); expect_state("load81", 8'h81, 1'b1);
    PL = 1'b0; SH = 1'b1; si = 1'b0;
    step(); expect_state("shift0", 8'h02, 1'b1);
    chk("so_shift0", {63'd0, so}, 64'd0);
    PL = 1'b1; SH = 1'b1; di = 8'h3C;
    step(); expect_state("load_beats_shift", 8'h3C, 1'b1);
    PL = 1'b0; SH = 1'b1; si = 1'b1;
    step(); expect_state("shift1_a", 8'h79, 1'b1);
    chk("so_shift1_a", {63'd0, so}, 64'd0);
    step(); expect_state("shift1_b", 8'hF3, 1'b1);
    chk("so_shift1_b", {63'd0, so}, 64'd1);
    // A shift right after reset must not raise vld.
    rst_n = 1'b0;
    step(); expect_state("rst_before_shift", 8'h00, 1'b0);
    rst_n = 1'b1; si = 1'b1;
    step(); expect_state("shift_no_vld", 8'h01, 1'b0);
    SH = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
